simd_mem_arbiter: RTL and testbench
===================================

Name: simd_mem_arbiter

Overview:
- Sits directly downstream of the SIMD processor's RAM port, between it and the 256-bit on-chip data RAM.
- Passes processor accesses straight through with zero added latency.
- Interleaves a host-side load/store port (image loader / result readback) into cycles where the processor does not touch RAM, or into any cycle while the processor is halted.
- Host side is a req/ack handshake with a small FSM and a read-latency tracker.

Parameters:
- ADDR_W, 14, RAM word address width.
- DATA_W, 256, RAM data width.
- BE_W, 32, byte-enable width (DATA_W/8).
- RD_LAT, 2, RAM read latency in cycles, from rden-cycle to valid ram_rdata (legal 1..4).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- cpu_address  in  ADDR_W  processor address
- cpu_byteena  in  BE_W  processor byte enables
- cpu_wdata  in  DATA_W  processor write data
- cpu_rden  in  1  processor read strobe
- cpu_wren  in  1  processor write strobe
- cpu_rdata  out  DATA_W  read data to processor
- cpu_halt  in  1  processor halted; host may use every cycle
- host_req  in  1  host request
- host_we  in  1  1=write, 0=read (sampled with req)
- host_address  in  ADDR_W  host address
- host_byteena  in  BE_W  host byte enables
- host_wdata  in  DATA_W  host write data
- host_ack  out  1  one-cycle completion pulse
- host_rdata  out  DATA_W  captured read data, valid with host_ack on reads
- ram_address  out  ADDR_W  to RAM
- ram_byteena  out  BE_W  to RAM
- ram_wdata  out  DATA_W  to RAM
- ram_rden  out  1  to RAM
- ram_wren  out  1  to RAM
- ram_rdata  in  DATA_W  from RAM

Behaviour:
- Reset (async): state IDLE, host_ack=0, host_rdata=0, latched host regs=0. Any in-flight host read is discarded; no ack is issued for it.
- cpu_active = (cpu_rden | cpu_wren) & ~cpu_halt.
- cpu_rdata = ram_rdata, combinational at all times.
- RAM mux is combinational:
  - In state ISSUE with ~cpu_active: RAM driven from the latched host regs; ram_rden = ~we_q, ram_wren = we_q.
  - Otherwise: RAM driven from cpu_* unchanged.
  - When cpu_halt=1, the cpu strobes are masked to 0.
- FSM:
  - IDLE: if host_req, latch host_we/address/byteena/wdata and go to ISSUE.
  - ISSUE: if cpu_active, stay (host stalled; processor always wins). Else issue to RAM. If write, go to DONE. If read, load cnt = RD_LAT-1 and go to RD_WAIT.
  - RD_WAIT: if cnt==0, host_rdata <= ram_rdata and go to DONE; else cnt--. Processor accesses pass freely in this state (RAM is pipelined).
  - DONE: host_ack=1 (registered, exactly one cycle), then go to IDLE.
- Host must hold host_req until ack. A req still high in the IDLE cycle after DONE starts a new transaction, so back-to-back transactions run at a minimum of 3 cycles each.
- Latency, uncontended:
  - Write: req sampled in cycle t, RAM write in t+1, ack in t+2.
  - Read: RAM read in t+1, capture at end of t+1+RD_LAT, ack in t+2+RD_LAT.
- host_rdata holds its value until the next read capture.
- cpu_rden and cpu_wren both high: both are forwarded unchanged; the RAM defines the result.
- cpu_halt rising mid-transaction: has effect only on the ISSUE decision; no other state change.

Optional Feature:
- Macro MEM_ARB_STATS_EN.
- Defined:
  - Adds output host_stall_cycles (16 bits): saturating count of cycles spent in ISSUE with cpu_active=1.
  - Adds output host_xfers (16 bits): saturating count of host_ack pulses.
  - Both reset to 0; neither wraps at 0xFFFF.
- Undefined: neither port nor any counter logic exists; all other behaviour is identical.

Test Plan:
- Reset then idle host; cpu_wren=1, addr 0x0010, data pattern A, byteena 0xFFFFFFFF; next cpu_rden addr 0x0010 -> ram_* mirror cpu_* same cycle; cpu_rdata = A after RD_LAT=2 cycles.
- cpu_halt=1, host write 0x1234 data B -> ram_wren in t+1, host_ack in t+2. Then host read 0x1234 -> host_ack in t+4 with host_rdata=B.
- cpu_halt=0, cpu_rden held high 5 cycles while host_req write pending -> no host RAM access for 5 cycles, host write issues in the first cpu-idle cycle, ack 1 cycle later; with MEM_ARB_STATS_EN, host_stall_cycles=5.
- Host read in RD_WAIT while cpu reads another address -> each read data returns to its owner: cpu_rdata and host_rdata carry distinct, correct words.
- Assert reset during RD_WAIT -> host_ack never pulses, host_rdata=0, state IDLE; next host read completes normally.
- Hold host_req high across DONE with 3 queued writes under cpu_halt -> exactly 3 ack pulses, spaced 3 cycles apart.

Source files
------------

// File: rtl/simd_mem_arbiter.sv
// rtl/simd_mem_arbiter.sv - zero-latency SIMD RAM port pass-through with host load/store interleaving
//
// Purpose:
//   Sits between the SIMD processor RAM port and the on-chip data RAM. Processor
//   accesses pass straight through combinationally. A host req/ack port is
//   interleaved into cycles where the processor does not touch RAM, or into any
//   cycle while the processor is halted. The processor always wins a conflict.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   cpu_address/byteena/wdata       processor access fields
//   cpu_rden, cpu_wren              processor strobes (masked while cpu_halt=1)
//   cpu_rdata                       RAM read data, combinational from ram_rdata
//   cpu_halt                        processor halted; host may use every cycle
//   host_req, host_we               host request (held until ack), 1=write
//   host_address/byteena/wdata      host access fields, sampled with host_req
//   host_ack                        one-cycle registered completion pulse
//   host_rdata                      captured read data, held until next read capture
//   ram_address/byteena/wdata       RAM command fields
//   ram_rden, ram_wren              RAM strobes
//   ram_rdata                       RAM read data, valid RD_LAT cycles after rden
//
// Optional build macro MEM_ARB_STATS_EN:
//   adds host_stall_cycles (cycles in ISSUE lost to the processor) and
//   host_xfers (completed host transfers), both 16-bit saturating.

module simd_mem_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 256,
  parameter int BE_W   = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [BE_W-1:0]   cpu_byteena,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_rden,
  input  logic              cpu_wren,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              cpu_halt,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_address,
  input  logic [BE_W-1:0]   host_byteena,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteena,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_rden,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]       host_stall_cycles,
  output logic [15:0]       host_xfers
`endif
);

  // Countdown covers RD_LAT-1 for the legal range 1..4.
  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RD_WAIT,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_d;
  logic              latch_req;
  logic              capture;

  logic              we_q;
  logic [ADDR_W-1:0] address_q;
  logic [BE_W-1:0]   byteena_q;
  logic [DATA_W-1:0] wdata_q;

  logic              cpu_active;
  logic              host_sel;

  assign cpu_active = (cpu_rden | cpu_wren) & ~cpu_halt;

  // Host owns the RAM only in the one ISSUE cycle the processor leaves free.
  assign host_sel = (state == S_ISSUE) & ~cpu_active;

  assign cpu_rdata = ram_rdata;

  always_comb begin
    ram_address = cpu_address;
    ram_byteena = cpu_byteena;
    ram_wdata   = cpu_wdata;
    ram_rden    = cpu_rden & ~cpu_halt;
    ram_wren    = cpu_wren & ~cpu_halt;
    if (host_sel) begin
      ram_address = address_q;
      ram_byteena = byteena_q;
      ram_wdata   = wdata_q;
      ram_rden    = ~we_q;
      ram_wren    = we_q;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    latch_req = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (host_req) begin
          latch_req = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!cpu_active) begin
          if (we_q) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = CNT_W'(RD_LAT - 1);
            state_d = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        // RAM is pipelined, so processor traffic in this window does not
        // disturb the host read already in flight.
        if (cnt == '0) begin
          capture = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      host_ack   <= 1'b0;
      host_rdata <= '0;
      we_q       <= 1'b0;
      address_q  <= '0;
      byteena_q  <= '0;
      wdata_q    <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      // Registered so the pulse coincides exactly with the DONE cycle.
      host_ack <= (state_d == S_DONE);
      if (latch_req) begin
        we_q      <= host_we;
        address_q <= host_address;
        byteena_q <= host_byteena;
        wdata_q   <= host_wdata;
      end
      if (capture) begin
        host_rdata <= ram_rdata;
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      host_stall_cycles <= '0;
      host_xfers        <= '0;
    end else begin
      if ((state == S_ISSUE) && cpu_active && (host_stall_cycles != 16'hFFFF)) begin
        host_stall_cycles <= host_stall_cycles + 16'd1;
      end
      if ((state_d == S_DONE) && (host_xfers != 16'hFFFF)) begin
        host_xfers <= host_xfers + 16'd1;
      end
    end
  end
`else
  // No statistics counters in this build.
`endif

endmodule

// File: tb/tb_simd_mem_arbiter.sv
// tb/tb_simd_mem_arbiter.sv - scoreboard bench for simd_mem_arbiter with a pipelined RAM model
module tb_simd_mem_arbiter;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 256;
  localparam int BE_W   = 32;
  localparam int RD_LAT = 2;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] cpu_address;
  logic [BE_W-1:0]   cpu_byteena;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_rden;
  logic              cpu_wren;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_halt;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_address;
  logic [BE_W-1:0]   host_byteena;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;
  logic [ADDR_W-1:0] ram_address;
  logic [BE_W-1:0]   ram_byteena;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_rden;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [15:0]       host_stall_cycles;
  logic [15:0]       host_xfers;
`endif

  simd_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_address(cpu_address), .cpu_byteena(cpu_byteena), .cpu_wdata(cpu_wdata),
    .cpu_rden(cpu_rden), .cpu_wren(cpu_wren), .cpu_rdata(cpu_rdata), .cpu_halt(cpu_halt),
    .host_req(host_req), .host_we(host_we), .host_address(host_address),
    .host_byteena(host_byteena), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .ram_address(ram_address), .ram_byteena(ram_byteena), .ram_wdata(ram_wdata),
    .ram_rden(ram_rden), .ram_wren(ram_wren), .ram_rdata(ram_rdata)
`ifdef MEM_ARB_STATS_EN
    ,
    .host_stall_cycles(host_stall_cycles), .host_xfers(host_xfers)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pipelined RAM: read data for an rden cycle appears RD_LAT cycles later.
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] pipe [RD_LAT];
  assign ram_rdata = pipe[RD_LAT-1];

  initial begin
    for (int i = 0; i < RD_LAT; i++) pipe[i] = '0;
  end

  always @(posedge clk) begin : ram_model
    logic [DATA_W-1:0] word;
    word = mem.exists(ram_address) ? mem[ram_address] : '0;
    pipe[0] <= ram_rden ? word : '0;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    if (ram_wren) begin
      for (int b = 0; b < BE_W; b++) begin
        if (ram_byteena[b]) word[8*b +: 8] = ram_wdata[8*b +: 8];
      end
      mem[ram_address] = word;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int                due;
    logic              rd;
    logic [DATA_W-1:0] data;
  } host_exp_t;

  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
  } cpu_exp_t;

  host_exp_t hq[$];
  cpu_exp_t  cq[$];

  always @(negedge clk) begin : monitor
    host_exp_t he;
    cpu_exp_t  ce;
    if (host_ack) begin
      if (hq.size() == 0) begin
        check("host_ack_unexpected", 256'(host_ack), 256'(0));
      end else begin
        he = hq.pop_front();
        check("host_ack_cycle", 256'(cyc), 256'(he.due));
        if (he.rd) check("host_rdata", host_rdata, he.data);
      end
    end
    if (cq.size() != 0 && cq[0].due == cyc) begin
      ce = cq.pop_front();
      check("cpu_rdata", cpu_rdata, ce.data);
    end
  end

  task automatic host_start(input logic we, input logic [ADDR_W-1:0] a, input logic [BE_W-1:0] be,
                            input logic [DATA_W-1:0] d, input int due);
    host_exp_t e;
    host_req     = 1'b1;
    host_we      = we;
    host_address = a;
    host_byteena = be;
    host_wdata   = we ? d : ~d;
    e.due  = due;
    e.rd   = ~we;
    e.data = d;
    hq.push_back(e);
  endtask

  task automatic cpu_expect(input logic [DATA_W-1:0] d);
    cpu_exp_t e;
    e.due  = cyc + RD_LAT;
    e.data = d;
    cq.push_back(e);
  endtask

  task automatic wait_ack();
    int n;
    n = 0;
    while (!host_ack && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("host_ack_seen", 256'(host_ack), 256'(1));
  endtask

  logic [DATA_W-1:0] pat_a, pat_b, pat_c, merged;
  logic [DATA_W-1:0] t6_data [3];
  logic [ADDR_W-1:0] t6_addr [3];
  logic [BE_W-1:0]   t6_be   [3];
  int t0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    pat_a = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0F1E2D3C4B5A6978, 64'h8796A5B4C3D2E1F0};
    pat_b = ~pat_a;
    pat_c = {pat_a[127:0], pat_b[255:128]};
    t6_data[0] = {8{32'hD00D_0000}};
    t6_data[1] = {8{32'h1111_2222}};
    t6_data[2] = {8{32'h5EED_C0DE}};
    t6_addr[0] = 14'h0300; t6_addr[1] = 14'h0301; t6_addr[2] = 14'h1234;
    t6_be[0]   = '1;       t6_be[1]   = '1;       t6_be[2]   = 32'h0000FFFF;
    merged     = {pat_b[255:128], t6_data[2][127:0]};

    reset = 1'b1; cpu_address = '0; cpu_byteena = '0; cpu_wdata = '0;
    cpu_rden = 1'b0; cpu_wren = 1'b0; cpu_halt = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_address = '0; host_byteena = '0; host_wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_host_ack", 256'(host_ack), 256'(0));
    check("rst_host_rdata", host_rdata, '0);
    check("rst_ram_rden", 256'(ram_rden), 256'(0));
    check("rst_ram_wren", 256'(ram_wren), 256'(0));
    reset = 1'b0;

    // Processor pass-through: write then read back
    @(negedge clk);
    cpu_wren = 1'b1; cpu_address = 14'h0010; cpu_wdata = pat_a; cpu_byteena = '1;
    #1;
    check("t1_wr_addr", 256'(ram_address), 256'(14'h0010));
    check("t1_wr_wren", 256'(ram_wren), 256'(1));
    check("t1_wr_data", ram_wdata, pat_a);
    check("t1_wr_be", 256'(ram_byteena), 256'(32'hFFFFFFFF));
    @(negedge clk);
    cpu_wren = 1'b0; cpu_rden = 1'b1; cpu_expect(pat_a);
    #1;
    check("t1_rd_rden", 256'(ram_rden), 256'(1));
    check("t1_rd_addr", 256'(ram_address), 256'(14'h0010));
    @(negedge clk);
    cpu_rden = 1'b0;
    repeat (3) @(negedge clk);

    // Halted processor: strobes masked, host write then read
    cpu_halt = 1'b1; cpu_wren = 1'b1; cpu_rden = 1'b1; cpu_address = 14'h0010; cpu_wdata = ~pat_a;
    #1;
    check("t2_halt_wren", 256'(ram_wren), 256'(0));
    check("t2_halt_rden", 256'(ram_rden), 256'(0));
    @(negedge clk);
    host_start(1'b1, 14'h1234, '1, pat_b, cyc + 2);
    @(negedge clk);
    #1;
    check("t2_issue_wren", 256'(ram_wren), 256'(1));
    check("t2_issue_addr", 256'(ram_address), 256'(14'h1234));
    check("t2_issue_data", ram_wdata, pat_b);
    wait_ack();
    host_req = 1'b0;
    @(negedge clk);
    host_start(1'b0, 14'h1234, '1, pat_b, cyc + RD_LAT + 2);
    wait_ack();
    host_req = 1'b0;
    cpu_wren = 1'b0; cpu_rden = 1'b0; cpu_halt = 1'b0;

    // Contention: processor reads for 5 cycles while a host write waits
    @(negedge clk);
    host_start(1'b1, 14'h0200, '1, pat_c, cyc + 7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cpu_rden = 1'b1; cpu_address = 14'h0010; cpu_expect(pat_a);
      #1;
      check("t3_stall_wren", 256'(ram_wren), 256'(0));
      check("t3_stall_addr", 256'(ram_address), 256'(14'h0010));
    end
    @(negedge clk);
    cpu_rden = 1'b0;
    #1;
    check("t3_issue_wren", 256'(ram_wren), 256'(1));
    check("t3_issue_addr", 256'(ram_address), 256'(14'h0200));
    wait_ack();
    host_req = 1'b0;
`ifdef MEM_ARB_STATS_EN
    check("t3_stall_cycles", 256'(host_stall_cycles), 256'(5));
    check("t3_xfers", 256'(host_xfers), 256'(3));
`endif

    // Host read in flight while processor reads a different word
    @(negedge clk);
    host_start(1'b0, 14'h1234, '1, pat_b, cyc + RD_LAT + 2);
    @(negedge clk);
    @(negedge clk);
    cpu_rden = 1'b1; cpu_address = 14'h0200; cpu_expect(pat_c);
    @(negedge clk);
    cpu_expect(pat_c);
    @(negedge clk);
    cpu_rden = 1'b0;
    wait_ack();
    host_req = 1'b0;

    // Reset during RD_WAIT discards the read
    @(negedge clk);
    host_start(1'b0, 14'h0200, '1, pat_c, cyc + RD_LAT + 2);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; host_req = 1'b0; hq.delete();
    #1;
    check("t5_rst_ack", 256'(host_ack), 256'(0));
    check("t5_rst_rdata", host_rdata, '0);
    check("t5_rst_rden", 256'(ram_rden), 256'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("t5_rdata_held0", host_rdata, '0);
    host_start(1'b0, 14'h0200, '1, pat_c, cyc + RD_LAT + 2);
    wait_ack();
    host_req = 1'b0;

    // Back-to-back writes with host_req held high across DONE
    cpu_halt = 1'b1;
    @(negedge clk);
    t0 = cyc;
    for (int k = 0; k < 3; k++) begin
      host_start(1'b1, t6_addr[k], t6_be[k], t6_data[k], t0 + 2 + 3 * k);
      @(negedge clk);
      wait_ack();
    end
    host_req = 1'b0;
    repeat (3) @(negedge clk);
    host_start(1'b0, 14'h1234, '1, merged, cyc + RD_LAT + 2);
    wait_ack();
    host_req = 1'b0;
    @(negedge clk);
    host_start(1'b0, 14'h0301, '1, t6_data[1], cyc + RD_LAT + 2);
    wait_ack();
    host_req = 1'b0;
    cpu_halt = 1'b0;

    repeat (5) @(negedge clk);
    check("host_q_drained", 256'(hq.size()), 256'(0));
    check("cpu_q_drained", 256'(cq.size()), 256'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
